load_tag_buffer: RTL and testbench
==================================

# load_tag_buffer

Tracks outstanding loads between the load unit and the write-through data cache in the 32-bit contest core. It allocates one of a small set of dcache request IDs per issued load and records the scoreboard transaction ID and the byte-lane information for that load. When the cache responds, it extracts and sign- or zero-extends the loaded value and writes the result back. It also absorbs responses for loads killed by a pipeline flush.

## Interface
- NR_ENTRIES, 2: outstanding loads; power of two, 2 or 4; matches the load-buffer depth setting.
- ID_W, $clog2(NR_ENTRIES): dcache request ID width (1 for the default configuration).
- TRANS_ID_W, 2: scoreboard transaction ID width (4 scoreboard entries).
- XLEN, 32: result width.
- DATA_W, 64: dcache read data width.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_valid_i  in  1  load issue request.
- req_ready_o  out  1  entry available; combinational.
- req_trans_id_i  in  TRANS_ID_W  scoreboard ID of the load.
- req_offset_i  in  3  byte offset within the 64-bit word.
- req_size_i  in  2  access size: 0 byte, 1 half, 2 word, 3 treated as word.
- req_signed_i  in  1  sign-extend the result.
- req_id_o  out  ID_W  allocated dcache ID; combinational; meaningful when req_valid_i & req_ready_o.
- rsp_valid_i  in  1  dcache read response; no backpressure.
- rsp_id_i  in  ID_W  ID of the response.
- rsp_data_i  in  DATA_W  read data.
- flush_i  in  1  kill all outstanding loads.
- res_valid_o  out  1  writeback valid; single-cycle pulse.
- res_trans_id_o  out  TRANS_ID_W  writeback scoreboard ID.
- res_data_o  out  XLEN  writeback data.
- empty_o  out  1  no entry allocated.

## Operation
- Per-entry state: valid, killed, trans_id, offset, size, signed.
- Allocation:
  - req_ready_o = (some entry has valid=0) & ~flush_i.
  - req_id_o selects the lowest-index free entry.
  - On handshake, set valid=1 and killed=0, and capture the request fields.
- Ready is computed from registered state only. An entry freed by a response in the same cycle is not reusable until the next cycle.
- Response handling for an entry with valid=1:
  - Clear valid.
  - If the entry has killed=0 and flush_i=0, produce a result.
  - Otherwise drop the response silently.
- A response to an entry with valid=0 is ignored. The bench flags it as a protocol error.
- Flush:
  - Sets killed=1 on every valid entry.
  - Entries stay allocated until their responses arrive, so IDs are never reused while the cache may still answer.
  - A response arriving in the flush cycle is dropped.
- Data extraction:
  - shifted = rsp_data_i >> (8 × offset); bytes shifted in are zero.
  - Byte: take shifted[7:0] and extend from bit 7.
  - Half: take shifted[15:0] and extend from bit 15.
  - Word or size 3: take shifted[31:0] with no extension.
  - Extension is sign extension if signed=1, otherwise zero extension.
- Misalignment is not checked; the issuing unit guarantees it.
- empty_o = no entry with valid=1. Killed entries count as allocated.

## Timing
- Reset values:
  - All entries have valid=0 and killed=0.
  - res_valid_o=0, res_trans_id_o=0, res_data_o=0.
  - After reset, req_ready_o=1 and empty_o=1.
- Allocation takes effect at the clock edge after the handshake. req_id_o is stable within the handshake cycle.
- Result latency:
  - res_* is registered; res_valid_o rises exactly one cycle after the accepted rsp_valid_i.
  - res_data_o and res_trans_id_o hold their last values when res_valid_o=0.
- One response per cycle yields at most one result per cycle; back-to-back results are supported.
- Simultaneous request and response on different entries: both are processed in the same cycle.
- Full: with NR_ENTRIES allocated, req_ready_o=0 until a response frees an entry. It rises the cycle after that response.
- Reset asserted mid-operation clears all state immediately, including killed entries. Responses arriving after reset are ignored.

## Test plan
- Load id buffer single load: issue trans_id=2, offset=4, size=0, signed=1; respond with data 0x0000_0080_0000_0000 one cycle later. Require res_valid_o one cycle after the response, res_trans_id_o=2, res_data_o=0xFFFF_FF80.
- Zero and half extension: offset=2, size=1, signed=0, data 0x0000_0000_BEEF_0000. Require res_data_o=0x0000_BEEF.
- Full and ordering:
  - Issue two loads; require IDs 0 then 1, then req_ready_o=0.
  - Respond to ID 1 first, then ID 0.
  - Require results in response order with the matching trans_ids.
  - req_ready_o returns to 1 the cycle after the first response.
- Flush with outstanding loads:
  - Issue two loads, assert flush_i for one cycle, then respond to both.
  - Require no res_valid_o and empty_o=1 after the second response.
  - A new request is accepted only after the entries are freed.
- Same-cycle events:
  - A response and a new request in the same cycle, with one entry free: require both handled.
  - A response in the flush cycle: require no result.
- Asynchronous reset between issue and response: require all outputs at reset values immediately, and the stale response produces no result.

Source files
------------

// File: rtl/load_tag_buffer.sv
// -----------------------------------------------------------------------------
// load_tag_buffer
//
// Tracks loads that are outstanding between the load unit and the
// write-through data cache. Each issued load takes one dcache request ID, and
// the entry for that ID stores the scoreboard transaction ID and the byte-lane
// details. When the cache answers, the loaded value is extracted, extended and
// written back one cycle later. After a flush, the entries stay allocated and
// marked killed until the cache answers them, so an ID is never reused while
// a response for it may still be in flight.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   req_valid_i          load issue request
//   req_ready_o          an entry is free and no flush is active (combinational)
//   req_trans_id_i       scoreboard ID of the issued load
//   req_offset_i         byte offset within the 64-bit cache word
//   req_size_i           0 byte, 1 half, 2/3 word
//   req_signed_i         sign-extend the result
//   req_id_o             dcache ID allocated for the request (combinational)
//   rsp_valid_i          dcache read response (no backpressure)
//   rsp_id_i             ID of the response
//   rsp_data_i           read data
//   flush_i              kill all outstanding loads
//   res_valid_o          writeback valid, single-cycle pulse (registered)
//   res_trans_id_o       writeback scoreboard ID (registered, holds)
//   res_data_o           writeback data (registered, holds)
//   empty_o              no entry allocated (killed entries count as allocated)
// -----------------------------------------------------------------------------
module load_tag_buffer #(
    parameter int NR_ENTRIES = 2,
    parameter int ID_W       = $clog2(NR_ENTRIES),
    parameter int TRANS_ID_W = 2,
    parameter int XLEN       = 32,
    parameter int DATA_W     = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [TRANS_ID_W-1:0] req_trans_id_i,
    input  logic [2:0]            req_offset_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_signed_i,
    output logic [ID_W-1:0]       req_id_o,
    input  logic                  rsp_valid_i,
    input  logic [ID_W-1:0]       rsp_id_i,
    input  logic [DATA_W-1:0]     rsp_data_i,
    input  logic                  flush_i,
    output logic                  res_valid_o,
    output logic [TRANS_ID_W-1:0] res_trans_id_o,
    output logic [XLEN-1:0]       res_data_o,
    output logic                  empty_o
);

    // Shift the addressed bytes down to bit 0, then extend from the access
    // width. Word accesses (size 2 and 3) are passed through unextended.
    function automatic logic [XLEN-1:0] extract_load(
        input logic [DATA_W-1:0] data,
        input logic [2:0]        offset,
        input logic [1:0]        size,
        input logic              sign_ext
    );
        logic [DATA_W-1:0] shifted;
        logic              ext_bit;
        logic [XLEN-1:0]   result;
        shifted = data >> {offset, 3'b000};
        case (size)
            2'd0: begin
                ext_bit = sign_ext & shifted[7];
                result  = {{(XLEN-8){ext_bit}}, shifted[7:0]};
            end
            2'd1: begin
                ext_bit = sign_ext & shifted[15];
                result  = {{(XLEN-16){ext_bit}}, shifted[15:0]};
            end
            default: begin
                ext_bit = 1'b0;
                result  = XLEN'(shifted[31:0]);
            end
        endcase
        return result;
    endfunction

    logic [NR_ENTRIES-1:0] valid_r;
    logic [NR_ENTRIES-1:0] killed_r;
    logic [TRANS_ID_W-1:0] trans_id_r [NR_ENTRIES];
    logic [2:0]            offset_r   [NR_ENTRIES];
    logic [1:0]            size_r     [NR_ENTRIES];
    logic                  signed_r   [NR_ENTRIES];

    logic                  res_valid_r;
    logic [TRANS_ID_W-1:0] res_trans_id_r;
    logic [XLEN-1:0]       res_data_r;

    logic                  any_free_s;
    logic [ID_W-1:0]       free_idx_s;
    logic                  req_fire_s;
    logic                  rsp_hit_s;
    logic                  res_fire_s;
    logic [XLEN-1:0]       res_data_s;

    // Lowest-index free entry; scanning downward lets the lowest index win.
    // Only registered state is used, so an entry freed this cycle is not
    // offered until the next one.
    always_comb begin
        any_free_s = ~&valid_r;
        free_idx_s = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                free_idx_s = ID_W'(i);
            end else begin
                free_idx_s = free_idx_s;
            end
        end
    end

    // Handshake, response qualification and extracted writeback data.
    always_comb begin
        req_fire_s = req_valid_i & any_free_s & ~flush_i;
        rsp_hit_s  = rsp_valid_i & valid_r[rsp_id_i];
        // A response in the flush cycle belongs to a killed load.
        res_fire_s = rsp_hit_s & ~killed_r[rsp_id_i] & ~flush_i;
        res_data_s = extract_load(rsp_data_i, offset_r[rsp_id_i],
                                  size_r[rsp_id_i], signed_r[rsp_id_i]);
    end

    // Entry allocation/free/kill and the registered writeback stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_r        <= '0;
            killed_r       <= '0;
            res_valid_r    <= 1'b0;
            res_trans_id_r <= '0;
            res_data_r     <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                trans_id_r[i] <= '0;
                offset_r[i]   <= 3'd0;
                size_r[i]     <= 2'd0;
                signed_r[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                // Allocation only targets a free entry and responses only
                // hit a valid one, so the two never address the same entry.
                if (req_fire_s && (free_idx_s == ID_W'(i))) begin
                    valid_r[i]    <= 1'b1;
                    killed_r[i]   <= 1'b0;
                    trans_id_r[i] <= req_trans_id_i;
                    offset_r[i]   <= req_offset_i;
                    size_r[i]     <= req_size_i;
                    signed_r[i]   <= req_signed_i;
                end else if (rsp_hit_s && (rsp_id_i == ID_W'(i))) begin
                    valid_r[i]  <= 1'b0;
                    killed_r[i] <= 1'b0;
                end else if (flush_i && valid_r[i]) begin
                    killed_r[i] <= 1'b1;
                end else begin
                    killed_r[i] <= killed_r[i];
                end
            end

            res_valid_r <= res_fire_s;
            if (res_fire_s) begin
                res_trans_id_r <= trans_id_r[rsp_id_i];
                res_data_r     <= res_data_s;
            end else begin
                res_trans_id_r <= res_trans_id_r;
                res_data_r     <= res_data_r;
            end
        end
    end

    assign req_ready_o    = any_free_s & ~flush_i;
    assign req_id_o       = free_idx_s;
    assign res_valid_o    = res_valid_r;
    assign res_trans_id_o = res_trans_id_r;
    assign res_data_o     = res_data_r;
    assign empty_o        = ~|valid_r;

endmodule

// File: tb/tb_load_tag_buffer.sv
module tb_load_tag_buffer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_trans_id_i;
    logic [2:0]  req_offset_i;
    logic [1:0]  req_size_i;
    logic        req_signed_i;
    logic [0:0]  req_id_o;
    logic        rsp_valid_i;
    logic [0:0]  rsp_id_i;
    logic [63:0] rsp_data_i;
    logic        flush_i;
    logic        res_valid_o;
    logic [1:0]  res_trans_id_o;
    logic [31:0] res_data_o;
    logic        empty_o;

    load_tag_buffer dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_trans_id_i (req_trans_id_i),
        .req_offset_i   (req_offset_i),
        .req_size_i     (req_size_i),
        .req_signed_i   (req_signed_i),
        .req_id_o       (req_id_o),
        .rsp_valid_i    (rsp_valid_i),
        .rsp_id_i       (rsp_id_i),
        .rsp_data_i     (rsp_data_i),
        .flush_i        (flush_i),
        .res_valid_o    (res_valid_o),
        .res_trans_id_o (res_trans_id_o),
        .res_data_o     (res_data_o),
        .empty_o        (empty_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  tid;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always @(posedge clk_i) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every result the DUT presents is matched against
    // the oldest expectation, including the cycle it was due in.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1 && res_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 64'(res_trans_id_o), 64'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_trans_id", 64'(res_trans_id_o), 64'(e.tid));
                check("res_data", 64'(res_data_o), 64'(e.data));
                check("res_latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        rsp_valid_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] tid, input logic [2:0] off,
                           input logic [1:0] size, input logic sgn);
        req_valid_i    = 1'b1;
        req_trans_id_i = tid;
        req_offset_i   = off;
        req_size_i     = size;
        req_signed_i   = sgn;
    endtask

    task automatic set_rsp(input logic [0:0] id, input logic [63:0] data);
        rsp_valid_i = 1'b1;
        rsp_id_i    = id;
        rsp_data_i  = data;
    endtask

    // Result is due in the cycle after the response is sampled.
    task automatic expect_res(input logic [1:0] tid, input logic [31:0] data);
        exp_q.push_back('{tid: tid, data: data, due: cyc + 1});
    endtask

    initial begin
        rst_ni = 1'b1;
        req_valid_i = 1'b0; req_trans_id_i = 2'd0; req_offset_i = 3'd0;
        req_size_i = 2'd0; req_signed_i = 1'b0;
        rsp_valid_i = 1'b0; rsp_id_i = 1'b0; rsp_data_i = 64'd0; flush_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        check("rst_res_valid", 64'(res_valid_o), 64'd0);
        check("rst_res_tid", 64'(res_trans_id_o), 64'd0);
        check("rst_res_data", 64'(res_data_o), 64'd0);
        check("rst_ready", 64'(req_ready_o), 64'd1);
        check("rst_empty", 64'(empty_o), 64'd1);
        tick; tick;
        rst_ni = 1'b1;

        // Single signed byte load.
        tick; set_req(2'd2, 3'd4, 2'd0, 1'b1); #1;
        check("t1_ready", 64'(req_ready_o), 64'd1);
        check("t1_id", 64'(req_id_o), 64'd0);
        tick; #1;
        check("t1_not_empty", 64'(empty_o), 64'd0);
        tick; set_rsp(1'b0, 64'h0000_0080_0000_0000); expect_res(2'd2, 32'hFFFF_FF80);
        tick; tick; #1;
        check("t1_empty", 64'(empty_o), 64'd1);

        // Zero-extended halfword.
        tick; set_req(2'd1, 3'd2, 2'd1, 1'b0);
        tick; set_rsp(1'b0, 64'h0000_0000_BEEF_0000); expect_res(2'd1, 32'h0000_BEEF);
        tick; tick;

        // Fill both entries, answer out of order.
        tick; set_req(2'd3, 3'd4, 2'd2, 1'b1); #1;
        check("t3_id0", 64'(req_id_o), 64'd0);
        tick; set_req(2'd0, 3'd0, 2'd2, 1'b0); #1;
        check("t3_id1", 64'(req_id_o), 64'd1);
        check("t3_ready1", 64'(req_ready_o), 64'd1);
        tick; #1;
        check("t3_full", 64'(req_ready_o), 64'd0);
        tick; set_rsp(1'b1, 64'hAAAA_AAAA_1234_5678); expect_res(2'd0, 32'h1234_5678); #1;
        check("t3_ready_rsp_cycle", 64'(req_ready_o), 64'd0);
        tick; set_rsp(1'b0, 64'h8765_4321_0000_0000); expect_res(2'd3, 32'h8765_4321); #1;
        check("t3_ready_after", 64'(req_ready_o), 64'd1);
        check("t3_free_id", 64'(req_id_o), 64'd1);
        tick; tick; #1;
        check("t3_empty", 64'(empty_o), 64'd1);

        // Flush with two outstanding loads.
        tick; set_req(2'd1, 3'd0, 2'd2, 1'b0);
        tick; set_req(2'd2, 3'd0, 2'd2, 1'b0);
        tick; flush_i = 1'b1; #1;
        check("t4_ready_flush", 64'(req_ready_o), 64'd0);
        tick; #1;
        check("t4_ready_killed", 64'(req_ready_o), 64'd0);
        check("t4_not_empty", 64'(empty_o), 64'd0);
        tick; set_rsp(1'b0, 64'h1111_1111_1111_1111); #1;
        check("t4_ready_rsp0", 64'(req_ready_o), 64'd0);
        tick; set_rsp(1'b1, 64'h2222_2222_2222_2222); #1;
        check("t4_ready_rsp1", 64'(req_ready_o), 64'd1);
        tick; tick; #1;
        check("t4_empty", 64'(empty_o), 64'd1);
        check("t4_ready", 64'(req_ready_o), 64'd1);

        // Response and request in the same cycle.
        tick; set_req(2'd1, 3'd0, 2'd0, 1'b0);
        tick; set_rsp(1'b0, 64'h0000_0000_0000_00FF); expect_res(2'd1, 32'h0000_00FF);
        set_req(2'd3, 3'd6, 2'd1, 1'b1); #1;
        check("t5_ready", 64'(req_ready_o), 64'd1);
        check("t5_id", 64'(req_id_o), 64'd1);
        tick; #1;
        check("t5_alloc", 64'(empty_o), 64'd0);
        tick; set_rsp(1'b1, 64'h8001_0000_0000_0000); expect_res(2'd3, 32'hFFFF_8001);
        tick; tick; #1;
        check("t5_empty", 64'(empty_o), 64'd1);

        // Response in the flush cycle is dropped.
        tick; set_req(2'd2, 3'd0, 2'd2, 1'b0);
        tick; flush_i = 1'b1; set_rsp(1'b0, 64'h0000_0000_5555_5555);
        tick; tick; #1;
        check("t5_flush_empty", 64'(empty_o), 64'd1);

        // Asynchronous reset between issue and response.
        tick; set_req(2'd3, 3'd0, 2'd2, 1'b0);
        tick; #1 rst_ni = 1'b0; #1;
        check("t6_res_valid", 64'(res_valid_o), 64'd0);
        check("t6_res_tid", 64'(res_trans_id_o), 64'd0);
        check("t6_res_data", 64'(res_data_o), 64'd0);
        check("t6_empty", 64'(empty_o), 64'd1);
        check("t6_ready", 64'(req_ready_o), 64'd1);
        tick; rst_ni = 1'b1;
        tick; set_rsp(1'b0, 64'h0000_0000_7777_7777);
        tick; tick; tick; #1;
        check("t6_empty_after", 64'(empty_o), 64'd1);

        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
